// File: rtl/led_blink_scheduler.sv
// rtl/led_blink_scheduler.sv - shared-tick two-channel LED blink scheduler with command port
//
// One prescaler divides Clock down to a scheduler tick. Each channel counts ticks
// up to its half-period and toggles its LED output on wrap. A two-state command
// FSM (IDLE/APPLY) accepts set-half, enable, disable and sync-all commands.
//
// Ports:
//   Clock        in   system clock, all logic on the rising edge
//   Reset_n      in   synchronous active-low reset
//   cfg_valid    in   command present
//   cfg_ready    out  high while the scheduler can accept a command
//   cfg_op       in   00 set half-period, 01 enable, 10 disable, 11 sync-all
//   cfg_channel  in   target channel (ignored for sync-all)
//   cfg_half     in   half-period in ticks (set half-period only)
//   IO_voltage   out  channel 0 LED drive (registered)
//   IO_voltage2  out  channel 1 LED drive (registered)

module led_blink_scheduler #(
    parameter int unsigned CLOCK_HZ      = 27_000_000,
    parameter int unsigned TICK_HZ       = 1000,
    parameter int unsigned DEFAULT_HALF0 = 500,
    parameter int unsigned DEFAULT_HALF1 = 100
) (
    input  logic        Clock,
    input  logic        Reset_n,
    input  logic        cfg_valid,
    output logic        cfg_ready,
    input  logic [1:0]  cfg_op,
    input  logic        cfg_channel,
    input  logic [15:0] cfg_half,
    output logic        IO_voltage,
    output logic        IO_voltage2
);

    localparam int unsigned TICK_DIV = CLOCK_HZ / TICK_HZ;
    localparam int unsigned PW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    generate
        if (TICK_DIV < 2) begin : g_bad_tick_div
            $error("led_blink_scheduler: CLOCK_HZ/TICK_HZ must be at least 2");
        end
    endgenerate

    localparam logic [1:0] OP_SET_HALF = 2'b00;
    localparam logic [1:0] OP_ENABLE   = 2'b01;
    localparam logic [1:0] OP_DISABLE  = 2'b10;
    localparam logic [1:0] OP_SYNC     = 2'b11;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_APPLY = 1'b1
    } state_t;

    state_t        state;
    logic [PW-1:0] presc;
    logic          tick;

    logic [1:0]    cap_op;
    logic          cap_channel;
    logic [15:0]   cap_half;

    logic [15:0]   half   [2];
    logic [15:0]   cnt    [2];
    logic [15:0]   eff_m1 [2];
    logic [1:0]    en;
    logic [1:0]    lvl;
    logic [1:0]    hit;

    assign tick        = (presc == PW'(TICK_DIV - 1));
    assign IO_voltage  = lvl[0];
    assign IO_voltage2 = lvl[1];

    // hit[ch]: the command executing this cycle touches channel ch, so that
    // channel ignores any coincident tick. Enabling an already-enabled channel
    // is a no-op and leaves tick processing alone.
    always_comb begin
        for (int ch = 0; ch < 2; ch++) begin
            hit[ch] = 1'b0;
            if (state == ST_APPLY) begin
                if (cap_op == OP_SYNC) begin
                    hit[ch] = 1'b1;
                end else if (cap_channel == 1'(ch)) begin
                    hit[ch] = (cap_op != OP_ENABLE) || !en[ch];
                end
            end
            // A stored half of 0 behaves as 1, i.e. wrap at count 0.
            eff_m1[ch] = (half[ch] == 16'd0) ? 16'd0 : half[ch] - 16'd1;
        end
    end

    always_ff @(posedge Clock) begin
        if (!Reset_n) begin
            state       <= ST_IDLE;
            cfg_ready   <= 1'b1;
            presc       <= '0;
            cap_op      <= 2'b00;
            cap_channel <= 1'b0;
            cap_half    <= 16'd0;
            half[0]     <= 16'(DEFAULT_HALF0);
            half[1]     <= 16'(DEFAULT_HALF1);
            cnt[0]      <= 16'd0;
            cnt[1]      <= 16'd0;
            en          <= 2'b11;
            lvl         <= 2'b00;
        end else begin
            // Sync-all restarts the prescaler so both channels re-align on it.
            if (state == ST_APPLY && cap_op == OP_SYNC) begin
                presc <= '0;
            end else if (tick) begin
                presc <= '0;
            end else begin
                presc <= presc + PW'(1);
            end

            case (state)
                ST_IDLE: begin
                    if (cfg_valid && cfg_ready) begin
                        cap_op      <= cfg_op;
                        cap_channel <= cfg_channel;
                        cap_half    <= cfg_half;
                        state       <= ST_APPLY;
                        cfg_ready   <= 1'b0;
                    end
                end
                ST_APPLY: begin
                    state     <= ST_IDLE;
                    cfg_ready <= 1'b1;
                end
                default: begin
                    state     <= ST_IDLE;
                    cfg_ready <= 1'b1;
                end
            endcase

            for (int ch = 0; ch < 2; ch++) begin
                if (hit[ch]) begin
                    cnt[ch] <= 16'd0;
                    case (cap_op)
                        OP_SET_HALF: half[ch] <= cap_half;
                        OP_ENABLE:   en[ch]   <= 1'b1;
                        OP_DISABLE: begin
                            en[ch]  <= 1'b0;
                            lvl[ch] <= 1'b0;
                        end
                        default:     lvl[ch]  <= 1'b0;
                    endcase
                end else if (tick && en[ch]) begin
                    if (cnt[ch] == eff_m1[ch]) begin
                        cnt[ch] <= 16'd0;
                        lvl[ch] <= ~lvl[ch];
                    end else begin
                        cnt[ch] <= cnt[ch] + 16'd1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_led_blink_scheduler.sv
// tb/tb_led_blink_scheduler.sv - self-checking bench for led_blink_scheduler

module tb_led_blink_scheduler;

    localparam int D     = 10;
    localparam int HALF0 = 3;
    localparam int HALF1 = 1;

    logic        Clock = 1'b0;
    logic        Reset_n = 1'b0;
    logic        cfg_valid = 1'b0;
    logic        cfg_ready;
    logic [1:0]  cfg_op = 2'b00;
    logic        cfg_channel = 1'b0;
    logic [15:0] cfg_half = 16'd0;
    logic        IO_voltage;
    logic        IO_voltage2;

    led_blink_scheduler #(
        .CLOCK_HZ      (10),
        .TICK_HZ       (1),
        .DEFAULT_HALF0 (HALF0),
        .DEFAULT_HALF1 (HALF1)
    ) dut (
        .Clock       (Clock),
        .Reset_n     (Reset_n),
        .cfg_valid   (cfg_valid),
        .cfg_ready   (cfg_ready),
        .cfg_op      (cfg_op),
        .cfg_channel (cfg_channel),
        .cfg_half    (cfg_half),
        .IO_voltage  (IO_voltage),
        .IO_voltage2 (IO_voltage2)
    );

    always #5 Clock = ~Clock;

    int checks   = 0;
    int failures = 0;

    // Reference model, expressed in absolute edge numbers: e is the current edge,
    // p0 the edge at which the prescaler last restarted (tick edges are p0+k*D, k>=1),
    // anchor[ch] the edge at which channel ch last restarted its half-period.
    // A channel toggles once eff_half tick edges have passed strictly after its anchor.
    int  e = 0;
    int  m_p0 = 0;
    int  m_anchor [2];
    int  m_half   [2];
    bit  m_en     [2];
    bit  m_lvl    [2];
    bit  m_apply  = 1'b0;
    int  cap_op, cap_ch, cap_half;

    function automatic int ticks_since(input int a, input int t);
        return (t - m_p0) / D - (a - m_p0) / D;
    endfunction

    task automatic chk(input string tag, input logic got, input logic exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s cycle=%0d got=%b exp=%b", tag, e, got, exp);
        end
    endtask

    task automatic step();
        bit [1:0] aff;
        int eh;
        e   = e + 1;
        aff = 2'b00;
        if (!Reset_n) begin
            m_p0    = e;
            m_apply = 1'b0;
            m_half[0] = HALF0;
            m_half[1] = HALF1;
            for (int c = 0; c < 2; c++) begin
                m_en[c] = 1'b1; m_lvl[c] = 1'b0; m_anchor[c] = e;
            end
        end else begin
            if (m_apply) begin
                m_apply = 1'b0;
                case (cap_op)
                    0: begin m_half[cap_ch] = cap_half; m_anchor[cap_ch] = e; aff[cap_ch] = 1'b1; end
                    1: if (!m_en[cap_ch]) begin
                           m_en[cap_ch] = 1'b1; m_anchor[cap_ch] = e; aff[cap_ch] = 1'b1;
                       end
                    2: begin
                           m_en[cap_ch] = 1'b0; m_lvl[cap_ch] = 1'b0;
                           m_anchor[cap_ch] = e; aff[cap_ch] = 1'b1;
                       end
                    default: begin
                        m_p0 = e;
                        for (int c = 0; c < 2; c++) begin
                            m_lvl[c] = 1'b0; m_anchor[c] = e;
                        end
                        aff = 2'b11;
                    end
                endcase
            end else if (cfg_valid) begin
                cap_op   = int'(cfg_op);
                cap_ch   = int'(cfg_channel);
                cap_half = int'(cfg_half);
                m_apply  = 1'b1;
            end
            for (int c = 0; c < 2; c++) begin
                if (!aff[c] && m_en[c]) begin
                    eh = (m_half[c] == 0) ? 1 : m_half[c];
                    if (ticks_since(m_anchor[c], e) == eh) begin
                        m_lvl[c]    = ~m_lvl[c];
                        m_anchor[c] = e;
                    end
                end
            end
        end
        @(posedge Clock);
        #1;
        chk("io0",   IO_voltage,  m_lvl[0]);
        chk("io1",   IO_voltage2, m_lvl[1]);
        chk("ready", cfg_ready,   !m_apply);
    endtask

    task automatic do_reset();
        cfg_valid = 1'b0;
        Reset_n   = 1'b0;
        step();
        step();
        Reset_n = 1'b1;
    endtask

    // Presents a command and holds cfg_valid until the edge that accepts it.
    task automatic send(input logic [1:0] op, input logic ch, input logic [15:0] h);
        bit acc;
        acc = 1'b0;
        cfg_op = op; cfg_channel = ch; cfg_half = h; cfg_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            acc = !m_apply;
            step();
            if (acc) break;
        end
        cfg_valid = 1'b0;
    endtask

    int a_edge;

    initial begin
        // Reset state and free-running blink with defaults.
        do_reset();
        chk("rst_io0", IO_voltage, 1'b0);
        chk("rst_io1", IO_voltage2, 1'b0);
        chk("rst_ready", cfg_ready, 1'b1);
        while (e - m_p0 < 40) begin
            step();
            if (e - m_p0 == 9)  chk("io1_before_first", IO_voltage2, 1'b0);
            if (e - m_p0 == 10) chk("io1_first", IO_voltage2, 1'b1);
            if (e - m_p0 == 20) chk("io1_second", IO_voltage2, 1'b0);
            if (e - m_p0 == 29) chk("io0_before_first", IO_voltage, 1'b0);
            if (e - m_p0 == 30) chk("io0_first", IO_voltage, 1'b1);
        end

        // Set channel 0 half=2 accepted at cycle 15.
        do_reset();
        while (e - m_p0 < 14) step();
        send(2'b00, 1'b0, 16'd2);
        step();
        chk("set_half_level_kept", IO_voltage, 1'b0);
        while (e - m_p0 < 50) begin
            step();
            if (e - m_p0 == 29) chk("half2_before", IO_voltage, 1'b0);
            if (e - m_p0 == 30) chk("half2_first", IO_voltage, 1'b1);
            if (e - m_p0 == 49) chk("half2_hold", IO_voltage, 1'b1);
            if (e - m_p0 == 50) chk("half2_second", IO_voltage, 1'b0);
        end

        // Disable channel 1 while high, then re-enable.
        for (int k = 0; k < 40 && !m_lvl[1]; k++) step();
        send(2'b10, 1'b1, 16'd0);
        step();
        chk("disable_low", IO_voltage2, 1'b0);
        repeat (25) step();
        chk("disabled_stays_low", IO_voltage2, 1'b0);
        send(2'b01, 1'b1, 16'd0);
        step();
        repeat (25) step();

        // Sync-all applied on a tick edge.
        do_reset();
        repeat (3) step();
        while ((e + 2 - m_p0) % D != 0) step();
        send(2'b11, 1'b0, 16'd0);
        step();
        a_edge = e;
        chk("sync_io0_low", IO_voltage, 1'b0);
        chk("sync_io1_low", IO_voltage2, 1'b0);
        while (e - a_edge < 35) begin
            step();
            if (e - a_edge == 9)  chk("sync_io1_before", IO_voltage2, 1'b0);
            if (e - a_edge == 10) chk("sync_io1_rise", IO_voltage2, 1'b1);
            if (e - a_edge == 29) chk("sync_io0_before", IO_voltage, 1'b0);
            if (e - a_edge == 30) chk("sync_io0_rise", IO_voltage, 1'b1);
        end

        // Back-to-back commands with cfg_valid held high; half=0 acts as 1.
        cfg_valid = 1'b1; cfg_op = 2'b00; cfg_channel = 1'b0; cfg_half = 16'd0;
        step();
        chk("b2b_ready0", cfg_ready, 1'b0);
        cfg_channel = 1'b1;
        step();
        chk("b2b_ready1", cfg_ready, 1'b1);
        step();
        chk("b2b_ready2", cfg_ready, 1'b0);
        cfg_valid = 1'b0;
        step();
        chk("b2b_ready3", cfg_ready, 1'b1);
        repeat (45) step();

        // Reset pulsed during APPLY discards the command and restores defaults.
        cfg_valid = 1'b1; cfg_op = 2'b10; cfg_channel = 1'b1; cfg_half = 16'd0;
        step();
        cfg_valid = 1'b0;
        Reset_n   = 1'b0;
        step();
        Reset_n = 1'b1;
        chk("mid_rst_ready", cfg_ready, 1'b1);
        while (e - m_p0 < 35) begin
            step();
            if (e - m_p0 == 10) chk("mid_rst_io1", IO_voltage2, 1'b1);
            if (e - m_p0 == 20) chk("mid_rst_io0_default", IO_voltage, 1'b0);
            if (e - m_p0 == 30) chk("mid_rst_io0", IO_voltage, 1'b1);
        end

        // Randomized commands against the model.
        for (int i = 0; i < 60; i++) begin
            repeat ($urandom_range(0, 40)) step();
            if ($urandom_range(0, 19) == 0) do_reset();
            send(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                 16'($urandom_range(0, 4)));
        end
        repeat (60) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog cycle=%0d got=running exp=finished", e);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/led_blink_scheduler.md
# led_blink_scheduler

Central controller for the board's two blink LEDs. It derives one shared millisecond tick from the 27 MHz system clock and runs a half-period counter for each LED. A small command port lets other logic set each LED's half-period, enable or disable either LED, and re-align both phases. It replaces per-LED free-running cycle counters with one prescaler and a runtime-configurable scheduler.

## Interface
- CLOCK_HZ, 27_000_000, system clock frequency
- TICK_HZ, 1000, scheduler tick rate; TICK_DIV = CLOCK_HZ/TICK_HZ, must be ≥ 2 (elaboration error otherwise)
- DEFAULT_HALF0, 500, channel 0 half-period in ticks after reset
- DEFAULT_HALF1, 100, channel 1 half-period in ticks after reset

- Clock  in  1  system clock; single clock domain, all logic on rising edge
- Reset_n  in  1  reset; synchronous, active-low
- cfg_valid  in  1  command present
- cfg_ready  out  1  scheduler can accept a command
- cfg_op  in  2  00 set half-period, 01 enable, 10 disable, 11 sync-all
- cfg_channel  in  1  target channel (ignored for sync-all)
- cfg_half  in  16  half-period in ticks (used by op 00 only)
- IO_voltage  out  1  channel 0 LED drive, registered
- IO_voltage2  out  1  channel 1 LED drive, registered

## Operation
- Prescaler: counts 0..TICK_DIV-1 and wraps. Internal tick is high for the cycle in which the count equals TICK_DIV-1.
- Per channel: half register (16 b), count register (16 b), enable bit, output bit.
- On a tick with the channel enabled:
  - if count == eff_half-1: count←0 and the output toggles;
  - else count←count+1.
  - eff_half = (half == 0) ? 1 : half. A stored 0 behaves as 1.
- A disabled channel holds its output at 0 and its count at 0. Ticks are ignored.
- Command FSM, two states:
  - IDLE: cfg_ready=1. On cfg_valid&&cfg_ready, capture op, channel and half, then go to APPLY.
  - APPLY: cfg_ready=0. Execute the captured command, then return to IDLE.
- Command effects, executed in APPLY:
  - 00: half←cfg_half; count←0; output level unchanged; enable unchanged.
  - 01: enable←1; count←0; output unchanged (0). No effect if the channel is already enabled.
  - 10: enable←0; count←0; output←0.
  - 11: prescaler←0; both counts←0; both outputs←0; enable bits and halves unchanged.
- Simultaneous events:
  - A command applied to a channel in the same cycle as a tick: the command wins and the tick is discarded for that channel only. The other channel processes the tick normally.
  - Sync-all in a tick cycle: the tick is discarded for both channels.
- Reset (Reset_n low at a rising edge):
  - prescaler=0; counts=0; outputs=0; both enables=1.
  - half0=DEFAULT_HALF0, half1=DEFAULT_HALF1.
  - FSM=IDLE; cfg_ready=1 in the first cycle after release.
  - Reset mid-command discards the captured command.
- Arithmetic: all counters are unsigned. The count never exceeds eff_half-1, so no overflow is possible.

## Timing
- Reset values: IO_voltage=0, IO_voltage2=0, cfg_ready=1.
- The first tick occurs TICK_DIV cycles after the edge that releases reset. The first toggle of a channel with half H occurs H·TICK_DIV cycles after release.
- Steady state: an enabled channel toggles every H·TICK_DIV cycles, so the full blink period is 2·H·TICK_DIV.
- Handshake:
  - A command is accepted on an edge with cfg_valid=1 and cfg_ready=1.
  - Its effect is visible on the outputs and internal registers after the next edge, at APPLY.
  - cfg_ready is low for exactly one cycle. Maximum throughput is one command per two cycles.
  - cfg_valid is ignored while cfg_ready=0; masters hold it until acceptance.
- After a set-half or sync command, the next toggle of the affected channel occurs a whole number of ticks later, measured on the free-running prescaler. Sync-all restarts the prescaler, so both channels re-align exactly: the next toggle is eff_half·TICK_DIV cycles after APPLY.

## Test plan
Bench parameters: CLOCK_HZ=10, TICK_HZ=1 (TICK_DIV=10), DEFAULT_HALF0=3, DEFAULT_HALF1=1.
- Reset release, no commands → IO_voltage2 toggles first at cycle 10 after release, then every 10 cycles. IO_voltage toggles first at cycle 30, then every 30. cfg_ready stays 1.
- Set channel 0 half=2 at cycle 15 → IO_voltage level is unchanged at APPLY. The next toggle falls on the first edge where count reaches 1, i.e. at the second tick after APPLY (cycle 30). Afterwards it toggles every 20 cycles.
- Disable channel 1 while IO_voltage2=1 → output is 0 after APPLY and stays 0. Re-enable → the first toggle to 1 arrives 1 tick later.
- Sync-all issued in the exact cycle of a tick → both outputs are 0 after APPLY and the tick is not counted. Channel 0 rises 30 cycles later and channel 1 rises 10 cycles later.
- Back-to-back commands with cfg_valid held high → accepted on alternating edges, cfg_ready pattern 1,0,1,0. Set half=0 → the channel toggles every 10 cycles, identical to half=1.
- Reset_n pulsed low during APPLY → the command has no effect and all outputs and defaults are restored as at power-up.
